cache_module: RTL and testbench

// - Single-level L2 cache controller model: per-set tag/MESI array, tree pseudo-LRU replacement, bus-operation and snoop-response generation.
// - Consumes one trace command per cycle (L1 requests plus snoops from other caches).
// - Emits bus ops, snoop results and L1 inclusivity messages; keeps hit/read/write/evict statistics.

---
 rtl/cache_pkg.sv | 47 ++++
 rtl/cache_plru.sv | 54 +++++
 rtl/cache_module.sv | 229 ++++++++++++++++++++++
 tb/tb_cache_module.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared encodings for the L2 cache controller model: trace commands, MESI states,
// snoop results, bus operations and L1 inclusivity messages.
package cache_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int OFFSET_W_DEF = 6;
    localparam int INDEX_W_DEF  = 6;
    localparam int WAYS_DEF     = 8;

    typedef enum logic [3:0] {
        CMD_DRD    = 4'd0,
        CMD_DWR    = 4'd1,
        CMD_IRD    = 4'd2,
        CMD_SNPINV = 4'd3,
        CMD_SNPRD  = 4'd4,
        CMD_SNPWR  = 4'd5,
        CMD_SNPRFO = 4'd6,
        CMD_CLEAR  = 4'd8,
        CMD_PRINT  = 4'd9
    } cmd_e;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_e;

    typedef enum logic [1:0] {
        SNP_HIT   = 2'd0,
        SNP_HITM  = 2'd1,
        SNP_NOHIT = 2'd2
    } snp_e;

    typedef enum logic [1:0] {
        BUS_RWIM  = 2'd0,
        BUS_READ  = 2'd1,
        BUS_WRITE = 2'd2,
        BUS_INVAL = 2'd3
    } bus_op_e;

    typedef enum logic [1:0] {
        L1_INVALIDATE = 2'd0,
        L1_EVICTLINE  = 2'd1
    } l1_msg_e;

endpackage

// File: rtl/cache_plru.sv
// Per-set tree pseudo-LRU: WAYS-1 heap-ordered bits per set (node n at bit n-1),
// a bit value of 0 steers the victim walk to the left child.
module cache_plru
    import cache_pkg::*;
#(
    parameter int SETS = 64,
    parameter int WAYS = WAYS_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear_i,
    input  logic [$clog2(SETS)-1:0]   set_i,
    input  logic                      upd_en_i,
    input  logic [$clog2(WAYS)-1:0]   upd_way_i,
    output logic [$clog2(WAYS)-1:0]   victim_o
);
    localparam int WAY_W = $clog2(WAYS);

    logic [WAYS-2:0]  tree_q [SETS];
    logic [WAYS-2:0]  tree_cur;
    logic [WAYS-2:0]  tree_d;
    logic [WAY_W-1:0] node_v;
    logic [WAY_W-1:0] node_u;

    // The final shift drops the leaf-level MSB, leaving the way number directly.
    always_comb begin
        tree_cur = tree_q[set_i];
        node_v   = WAY_W'(1);
        for (int l = 0; l < WAY_W; l++) begin
            node_v = {node_v[WAY_W-2:0], tree_cur[node_v - 1'b1]};
        end
        victim_o = node_v;
    end

    always_comb begin
        tree_d = tree_cur;
        node_u = WAY_W'(1);
        for (int l = 0; l < WAY_W; l++) begin
            tree_d[node_u - 1'b1] = ~upd_way_i[WAY_W-1-l];
            node_u = {node_u[WAY_W-2:0], upd_way_i[WAY_W-1-l]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            for (int s = 0; s < SETS; s++) begin
                tree_q[s] <= '0;
            end
        end else if (upd_en_i) begin
            tree_q[set_i] <= tree_d;
        end
    end

endmodule

// File: rtl/cache_module.sv
// L2 cache controller model: tag/MESI arrays, hit and empty-way search, MESI next-state,
// registered bus/snoop/L1 pulses and statistics counters.
module cache_module
    import cache_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int OFFSET_W = OFFSET_W_DEF,
    parameter int INDEX_W  = INDEX_W_DEF,
    parameter int WAYS     = WAYS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [3:0]        cmd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        snoop_in,
    output logic              bus_valid,
    output logic [1:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [1:0]        snoop_out,
    output logic              snoop_valid,
    output logic              l1_valid,
    output logic [1:0]        l1_msg,
    output logic [ADDR_W-1:0] l1_addr,
    output logic [31:0]       hit_count,
    output logic [31:0]       read_count,
    output logic [31:0]       write_count,
    output logic [31:0]       evict_count
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SETS  = 1 << INDEX_W;
    localparam int WAY_W = $clog2(WAYS);
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    mesi_e            state_q [SETS][WAYS];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [ADDR_W-1:0]  line_addr, vic_addr;
    logic               hit, has_empty;
    logic [WAY_W-1:0]   hit_way, empty_way, plru_victim, vic_way;
    mesi_e              hit_state, vic_state;

    logic               arr_we, do_fill, plru_upd, clear_all;
    logic [WAY_W-1:0]   arr_way, plru_way;
    mesi_e              arr_state, fill_state;

    logic               bus_valid_q, bus_valid_d, wb_valid_q, wb_valid_d;
    logic               snoop_valid_q, snoop_valid_d, l1_valid_q, l1_valid_d;
    bus_op_e            bus_op_q, bus_op_d;
    snp_e               snoop_out_q, snoop_out_d;
    l1_msg_e            l1_msg_q, l1_msg_d;
    logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d, wb_addr_q, wb_addr_d, l1_addr_q, l1_addr_d;
    logic [31:0]        hit_q, hit_d, rd_q, rd_d, wr_q, wr_d, ev_q, ev_d;

    assign idx       = addr[OFFSET_W +: INDEX_W];
    assign tag       = addr[ADDR_W-1 -: TAG_W];
    assign line_addr = addr & LINE_MASK;
    assign hit_state = state_q[idx][hit_way];
    assign vic_way   = has_empty ? empty_way : plru_victim;
    assign vic_state = state_q[idx][vic_way];
    assign vic_addr  = {tag_q[idx][vic_way], idx, {OFFSET_W{1'b0}}};

    cache_plru #(.SETS(SETS), .WAYS(WAYS)) u_plru (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear_all),
        .set_i     (idx),
        .upd_en_i  (plru_upd),
        .upd_way_i (plru_way),
        .victim_o  (plru_victim)
    );

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        has_empty = 1'b0;
        empty_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && state_q[idx][w] != MESI_I && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!has_empty && state_q[idx][w] == MESI_I) begin
                has_empty = 1'b1;
                empty_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        bus_valid_d = 1'b0;  bus_op_d = BUS_RWIM;      bus_addr_d = '0;
        wb_valid_d  = 1'b0;  wb_addr_d = '0;
        snoop_valid_d = 1'b0; snoop_out_d = SNP_NOHIT;
        l1_valid_d  = 1'b0;  l1_msg_d = L1_INVALIDATE; l1_addr_d = '0;
        hit_d = hit_q; rd_d = rd_q; wr_d = wr_q; ev_d = ev_q;
        arr_we = 1'b0; arr_way = hit_way; arr_state = MESI_I;
        do_fill = 1'b0; fill_state = MESI_E;
        plru_upd = 1'b0; plru_way = hit_way; clear_all = 1'b0;
        if (cmd_valid) begin
            case (cmd)
                CMD_DRD, CMD_IRD: begin
                    rd_d = rd_q + 32'd1;
                    if (hit) begin
                        hit_d = hit_q + 32'd1;
                        plru_upd = 1'b1;
                    end else begin
                        do_fill = 1'b1;
                        fill_state = (snoop_in == SNP_HIT || snoop_in == SNP_HITM) ? MESI_S : MESI_E;
                        bus_valid_d = 1'b1; bus_op_d = BUS_READ; bus_addr_d = line_addr;
                    end
                end
                CMD_DWR: begin
                    wr_d = wr_q + 32'd1;
                    if (hit) begin
                        hit_d = hit_q + 32'd1;
                        plru_upd = 1'b1;
                        arr_we = 1'b1; arr_state = MESI_M;
                        if (hit_state == MESI_S) begin
                            bus_valid_d = 1'b1; bus_op_d = BUS_INVAL; bus_addr_d = line_addr;
                        end
                    end else begin
                        do_fill = 1'b1; fill_state = MESI_M;
                        bus_valid_d = 1'b1; bus_op_d = BUS_RWIM; bus_addr_d = line_addr;
                    end
                end
                CMD_SNPRD, CMD_SNPRFO: begin
                    snoop_valid_d = 1'b1;
                    if (hit) begin
                        arr_we = 1'b1;
                        arr_state = (cmd == CMD_SNPRD) ? MESI_S : MESI_I;
                        snoop_out_d = (hit_state == MESI_M) ? SNP_HITM : SNP_HIT;
                        if (hit_state == MESI_M) begin
                            bus_valid_d = 1'b1; bus_op_d = BUS_WRITE; bus_addr_d = line_addr;
                        end
                        if (cmd == CMD_SNPRFO) begin
                            l1_valid_d = 1'b1; l1_msg_d = L1_INVALIDATE; l1_addr_d = line_addr;
                        end
                    end
                end
                CMD_SNPWR: snoop_valid_d = 1'b1;
                CMD_SNPINV: begin
                    if (hit && hit_state == MESI_S) begin
                        arr_we = 1'b1; arr_state = MESI_I;
                        l1_valid_d = 1'b1; l1_msg_d = L1_INVALIDATE; l1_addr_d = line_addr;
                    end
                end
                CMD_CLEAR: begin
                    clear_all = 1'b1;
                    hit_d = '0; rd_d = '0; wr_d = '0;
                end
                default: ;
            endcase
        end
        // A miss always lands in vic_way; only a fully valid set actually evicts.
        if (do_fill) begin
            arr_we = 1'b1; arr_way = vic_way; arr_state = fill_state;
            plru_upd = 1'b1; plru_way = vic_way;
            if (!has_empty) begin
                ev_d = ev_q + 32'd1;
                l1_valid_d = 1'b1; l1_addr_d = vic_addr;
                if (vic_state == MESI_M) begin
                    wb_valid_d = 1'b1; wb_addr_d = vic_addr; l1_msg_d = L1_EVICTLINE;
                end else begin
                    l1_msg_d = L1_INVALIDATE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_valid_q <= 1'b0; wb_valid_q <= 1'b0; snoop_valid_q <= 1'b0; l1_valid_q <= 1'b0;
            hit_q <= '0; rd_q <= '0; wr_q <= '0; ev_q <= '0;
        end else begin
            bus_valid_q <= bus_valid_d; wb_valid_q <= wb_valid_d;
            snoop_valid_q <= snoop_valid_d; l1_valid_q <= l1_valid_d;
            hit_q <= hit_d; rd_q <= rd_d; wr_q <= wr_d; ev_q <= ev_d;
        end
    end

    always_ff @(posedge clk) begin
        bus_op_q <= bus_op_d; bus_addr_q <= bus_addr_d; wb_addr_q <= wb_addr_d;
        snoop_out_q <= snoop_out_d; l1_msg_q <= l1_msg_d; l1_addr_q <= l1_addr_d;
    end

    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    state_q[s][w] <= MESI_I;
                end
            end
        end else if (arr_we) begin
            state_q[idx][arr_way] <= arr_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w] <= '0;
                end
            end
        end else if (arr_we) begin
            tag_q[idx][arr_way] <= tag;
        end
    end

    assign bus_valid   = bus_valid_q;
    assign bus_op      = bus_op_q;
    assign bus_addr    = bus_addr_q;
    assign wb_valid    = wb_valid_q;
    assign wb_addr     = wb_addr_q;
    assign snoop_valid = snoop_valid_q;
    assign snoop_out   = snoop_out_q;
    assign l1_valid    = l1_valid_q;
    assign l1_msg      = l1_msg_q;
    assign l1_addr     = l1_addr_q;
    assign hit_count   = hit_q;
    assign read_count  = rd_q;
    assign write_count = wr_q;
    assign evict_count = ev_q;

endmodule

// File: tb/tb_cache_module.sv
// Bench for cache_module: directed vector table, Clear/reset sequences, and random
// traffic checked against a set/way/PLRU-tree reference model.
module tb_cache_module;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd = '0;
    logic [31:0] addr = '0;
    logic [1:0]  snoop_in = 2'd2;
    logic        bus_valid, wb_valid, snoop_valid, l1_valid;
    logic [1:0]  bus_op, snoop_out, l1_msg;
    logic [31:0] bus_addr, wb_addr, l1_addr;
    logic [31:0] hit_count, read_count, write_count, evict_count;

    int checks   = 0;
    int failures = 0;

    cache_module dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .addr(addr),
        .snoop_in(snoop_in), .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .snoop_out(snoop_out),
        .snoop_valid(snoop_valid), .l1_valid(l1_valid), .l1_msg(l1_msg), .l1_addr(l1_addr),
        .hit_count(hit_count), .read_count(read_count), .write_count(write_count),
        .evict_count(evict_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        bv; logic [1:0] bop; logic [31:0] ba;
        logic        wv; logic [31:0] wa;
        logic        sv; logic [1:0] so;
        logic        lv; logic [1:0] lm; logic [31:0] la;
    } out_t;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [1:0]  sn;
        out_t        e;
    } vec_t;

    function automatic vec_t mk(int c, int unsigned a, int sn, int bv, int bop, int unsigned ba,
                                int wv, int unsigned wa, int sv, int so, int lv, int lm,
                                int unsigned la);
        vec_t v;
        v.c = 4'(c); v.a = a; v.sn = 2'(sn);
        v.e.bv = bv[0]; v.e.bop = 2'(bop); v.e.ba = ba;
        v.e.wv = wv[0]; v.e.wa = wa;
        v.e.sv = sv[0]; v.e.so = 2'(so);
        v.e.lv = lv[0]; v.e.lm = 2'(lm); v.e.la = la;
        return v;
    endfunction

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    task automatic cmp_out(input string nm, input out_t e);
        chk({nm, " bus_valid"}, 32'(bus_valid), 32'(e.bv));
        if (e.bv) begin
            chk({nm, " bus_op"}, 32'(bus_op), 32'(e.bop));
            chk({nm, " bus_addr"}, bus_addr, e.ba);
        end
        chk({nm, " wb_valid"}, 32'(wb_valid), 32'(e.wv));
        if (e.wv) chk({nm, " wb_addr"}, wb_addr, e.wa);
        chk({nm, " snoop_valid"}, 32'(snoop_valid), 32'(e.sv));
        if (e.sv) chk({nm, " snoop_out"}, 32'(snoop_out), 32'(e.so));
        chk({nm, " l1_valid"}, 32'(l1_valid), 32'(e.lv));
        if (e.lv) begin
            chk({nm, " l1_msg"}, 32'(l1_msg), 32'(e.lm));
            chk({nm, " l1_addr"}, l1_addr, e.la);
        end
    endtask

    task automatic chk_cnt(input string nm, input int unsigned h, input int unsigned r,
                           input int unsigned w, input int unsigned ev);
        chk({nm, " hit_count"}, hit_count, h);
        chk({nm, " read_count"}, read_count, r);
        chk({nm, " write_count"}, write_count, w);
        chk({nm, " evict_count"}, evict_count, ev);
    endtask

    task automatic do_cmd(input logic [3:0] c, input logic [31:0] a, input logic [1:0] sn);
        @(negedge clk);
        cmd_valid = 1'b1; cmd = c; addr = a; snoop_in = sn;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Reference model: states 0 I, 1 S, 2 E, 3 M; PLRU tree as heap nodes 1..7 per set.
    int unsigned m_st  [64][8];
    int unsigned m_tag [64][8];
    bit          m_tree[64][8];
    int unsigned m_hit, m_rd, m_wr, m_ev;

    task automatic model_clear();
        for (int s = 0; s < 64; s++)
            for (int w = 0; w < 8; w++) begin
                m_st[s][w] = 0; m_tree[s][w] = 1'b0;
            end
        m_hit = 0; m_rd = 0; m_wr = 0;
    endtask

    task automatic model_reset();
        model_clear();
        for (int s = 0; s < 64; s++)
            for (int w = 0; w < 8; w++) m_tag[s][w] = 0;
        m_ev = 0;
    endtask

    task automatic model_touch(input int s, input int w);
        int n;
        n = w + 8;
        while (n > 1) begin
            m_tree[s][n / 2] = (n % 2 == 0);
            n = n / 2;
        end
    endtask

    function automatic int model_victim(int s);
        int n;
        n = 1;
        while (n < 8) n = 2 * n + int'(m_tree[s][n]);
        return n - 8;
    endfunction

    task automatic model_step(input logic [3:0] c, input logic [31:0] a, input logic [1:0] sn,
                              output out_t e);
        int s, hw, w, fs;
        int unsigned tg, line, va;
        s = int'((a >> 6) & 32'h3F);
        tg = a >> 12;
        line = a & 32'hFFFF_FFC0;
        e = '0;
        hw = -1;
        fs = -1;
        for (int i = 0; i < 8; i++)
            if (m_st[s][i] != 0 && m_tag[s][i] == tg) hw = i;
        case (c)
            4'd0, 4'd2: begin
                m_rd++;
                if (hw >= 0) begin m_hit++; model_touch(s, hw); end
                else begin
                    fs = (sn == 2'd0 || sn == 2'd1) ? 1 : 2;
                    e.bv = 1'b1; e.bop = 2'd1; e.ba = line;
                end
            end
            4'd1: begin
                m_wr++;
                if (hw >= 0) begin
                    m_hit++;
                    if (m_st[s][hw] == 1) begin e.bv = 1'b1; e.bop = 2'd3; e.ba = line; end
                    m_st[s][hw] = 3;
                    model_touch(s, hw);
                end else begin
                    fs = 3;
                    e.bv = 1'b1; e.bop = 2'd0; e.ba = line;
                end
            end
            4'd4, 4'd6: begin
                e.sv = 1'b1; e.so = 2'd2;
                if (hw >= 0) begin
                    if (m_st[s][hw] == 3) begin
                        e.so = 2'd1; e.bv = 1'b1; e.bop = 2'd2; e.ba = line;
                    end else e.so = 2'd0;
                    m_st[s][hw] = (c == 4'd4) ? 1 : 0;
                    if (c == 4'd6) begin e.lv = 1'b1; e.lm = 2'd0; e.la = line; end
                end
            end
            4'd5: begin e.sv = 1'b1; e.so = 2'd2; end
            4'd3: begin
                if (hw >= 0 && m_st[s][hw] == 1) begin
                    m_st[s][hw] = 0;
                    e.lv = 1'b1; e.lm = 2'd0; e.la = line;
                end
            end
            4'd8: model_clear();
            default: ;
        endcase
        if (fs >= 0) begin
            w = -1;
            for (int i = 0; i < 8; i++)
                if (w < 0 && m_st[s][i] == 0) w = i;
            if (w < 0) begin
                w = model_victim(s);
                m_ev++;
                va = (m_tag[s][w] << 12) | (s << 6);
                e.lv = 1'b1; e.la = va;
                if (m_st[s][w] == 3) begin e.wv = 1'b1; e.wa = va; e.lm = 2'd1; end
                else e.lm = 2'd0;
            end
            m_st[s][w] = fs;
            m_tag[s][w] = tg;
            model_touch(s, w);
        end
    endtask

    vec_t tbl[$];

    initial begin
        out_t e;
        logic [3:0]  rc;
        logic [31:0] ra;
        logic [1:0]  rs;
        int unsigned r;

        // Directed trace; rows: cmd, addr, snoop_in, then expected outputs.
        tbl.push_back(mk(0, 32'h1000, 2, 1, 1, 32'h1000, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h1000, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h1000, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h2000, 0, 1, 1, 32'h2000, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h2000, 2, 1, 3, 32'h2000, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4, 32'h2000, 2, 1, 2, 32'h2000, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 32'h2000, 2, 1, 3, 32'h2000, 0, 0, 0, 0, 0, 0, 0));
        for (int t = 3; t <= 8; t++)
            tbl.push_back(mk(0, t << 12, 2, 1, 1, t << 12, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h9000, 2, 1, 0, 32'h9000, 1, 32'h1000, 0, 0, 1, 1, 32'h1000));
        tbl.push_back(mk(0, 32'hA000, 2, 1, 1, 32'hA000, 0, 0, 0, 0, 1, 0, 32'h5000));
        tbl.push_back(mk(6, 32'h3000, 2, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h3000));
        tbl.push_back(mk(6, 32'h3000, 2, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
        tbl.push_back(mk(0, 32'h3000, 0, 1, 1, 32'h3000, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(3, 32'h3000, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h3000));
        tbl.push_back(mk(0, 32'h3000, 2, 1, 1, 32'h3000, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(5, 32'h3000, 2, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
        tbl.push_back(mk(3, 32'h3000, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4, 32'h4000, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(4, 32'h55000, 2, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
        tbl.push_back(mk(9, 32'h1000, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(7, 32'h2000, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h12340047, 2, 1, 0, 32'h12340040, 0, 0, 0, 0, 0, 0, 0));

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cmp_out("reset", '0);
        chk_cnt("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            do_cmd(tbl[i].c, tbl[i].a, tbl[i].sn);
            cmp_out($sformatf("vec%0d", i), tbl[i].e);
        end
        chk_cnt("table end", 4, 12, 5, 2);

        // Clear keeps only evict_count; the S line at 0x4000 must now miss.
        do_cmd(4'd8, 32'h0, 2'd2);
        cmp_out("clear", '0);
        chk_cnt("clear", 0, 0, 0, 2);
        do_cmd(4'd0, 32'h4000, 2'd2);
        cmp_out("post-clear miss", mk(0, 0, 0, 1, 1, 32'h4000, 0, 0, 0, 0, 0, 0, 0).e);
        do_cmd(4'd0, 32'h4000, 2'd2);
        cmp_out("post-clear hit", '0);
        chk_cnt("post-clear", 1, 2, 0, 2);

        // Reset mid-trace with a command present: everything zero next cycle.
        @(negedge clk);
        rst = 1'b1; cmd_valid = 1'b1; cmd = 4'd1; addr = 32'h4000;
        @(posedge clk);
        #1;
        cmp_out("mid reset", '0);
        chk_cnt("mid reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0;
        do_cmd(4'd0, 32'h4000, 2'd2);
        cmp_out("post-reset miss", mk(0, 0, 0, 1, 1, 32'h4000, 0, 0, 0, 0, 0, 0, 0).e);
        chk_cnt("post-reset", 0, 1, 0, 0);

        // Random traffic on two sets with twelve tags, so evictions are frequent.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30)      rc = 4'd0;
            else if (r < 40) rc = 4'd2;
            else if (r < 60) rc = 4'd1;
            else if (r < 67) rc = 4'd3;
            else if (r < 75) rc = 4'd4;
            else if (r < 80) rc = 4'd5;
            else if (r < 88) rc = 4'd6;
            else if (r < 89) rc = 4'd8;
            else if (r < 93) rc = 4'd9;
            else if (r < 94) rc = 4'd7;
            else             rc = 4'($urandom_range(10, 15));
            ra = (32'($urandom_range(1, 12)) << 12) | (32'($urandom_range(0, 1)) << 6)
               | 32'($urandom_range(0, 63));
            rs = 2'($urandom_range(0, 3));
            model_step(rc, ra, rs, e);
            do_cmd(rc, ra, rs);
            cmp_out($sformatf("rnd%0d c%0d a%08h", i, rc, ra), e);
            chk_cnt($sformatf("rnd%0d", i), m_hit, m_rd, m_wr, m_ev);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
